// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace buffer.
// Optional drop counter is enabled by defining WB_TRACE_DROPCNT_EN.
package wb_trace_pkg;
  localparam int RD_W       = 5;
  localparam int CYC_W_DEF  = 12;
  localparam int DATA_W_DEF = 32;

  localparam logic [RD_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [CYC_W_DEF-1:0]  cycle;
    logic [RD_W-1:0]       rd;
    logic [DATA_W_DEF-1:0] data;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

  function automatic int entry_width(input int cyc_w, input int data_w);
    return cyc_w + RD_W + data_w;
  endfunction
endpackage

// File: rtl/trace_fifo_mem.sv
// Trace FIFO storage: one synchronous write port, one asynchronous read port.
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 49
) (
  input  logic                     clock,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] write_addr,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [$clog2(DEPTH)-1:0] read_addr,
  output logic [WIDTH-1:0]         read_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];
endmodule

// File: rtl/wb_trace_buffer.sv
// Timestamped capture of regfile writebacks into a show-ahead circular FIFO.
// Define WB_TRACE_DROPCNT_EN to build the saturating dropped-event counter.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 12,
  parameter int DATA_W = 32,
  parameter int DROP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     ctrl_writeEnable,
  input  logic [RD_W-1:0]          ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W-1:0]         out_cycle,
  output logic [RD_W-1:0]          out_rd,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_width(CYC_W, DATA_W);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CYC_W-1:0] cycle_cnt;
  logic [EW-1:0]    wr_entry, rd_entry;
  logic             full, push_req, pop, push_ok, drop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign push_req = enable && ctrl_writeEnable && (ctrl_writeReg != REG_X0);
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign wr_entry = {cycle_cnt, ctrl_writeReg, data_writeReg};

  trace_fifo_mem #(.DEPTH(DEPTH), .WIDTH(EW)) u_mem (
    .clock      (clock),
    .write_en   (push_ok && !clear),
    .write_addr (wr_ptr[AW-1:0]),
    .write_data (wr_entry),
    .read_addr  (rd_ptr[AW-1:0]),
    .read_data  (rd_entry)
  );

  // Storage is not reset, so the head fields are forced to zero while empty.
  assign out_cycle = out_valid ? rd_entry[EW-1 -: CYC_W]   : '0;
  assign out_rd    = out_valid ? rd_entry[DATA_W +: RD_W]  : '0;
  assign out_data  = out_valid ? rd_entry[DATA_W-1:0]      : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cycle_cnt <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cycle_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (enable)  cycle_cnt <= cycle_cnt + CYC_W'(1);
      if (push_ok) wr_ptr    <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr    <= rd_ptr + PTR_ONE;
      if (drop)    overflow  <= 1'b1;
    end
  end

`ifdef WB_TRACE_DROPCNT_EN
  logic [DROP_W-1:0] drop_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (main build plus a CYC_W=4 instance).
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

`ifdef WB_TRACE_DROPCNT_EN
  localparam int EXP_DROP1 = 1;
`else
  localparam int EXP_DROP1 = 0;
`endif

  logic        clock, reset, enable, clear, ctrl_writeEnable, out_ready;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  logic        out_valid, overflow;
  logic [11:0] out_cycle;
  logic [4:0]  out_rd, count;
  logic [31:0] out_data;
  logic [15:0] drop_count;

  logic        d4_out_valid, d4_overflow;
  logic [3:0]  d4_out_cycle;
  logic [4:0]  d4_out_rd, d4_count;
  logic [31:0] d4_out_data;
  logic [15:0] d4_drop_count;

  int checks = 0;
  int errors = 0;

  wb_trace_buffer #(.DEPTH(16), .CYC_W(12), .DATA_W(32), .DROP_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .out_valid(out_valid), .out_ready(out_ready),
    .out_cycle(out_cycle), .out_rd(out_rd), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  wb_trace_buffer #(.DEPTH(16), .CYC_W(4), .DATA_W(32), .DROP_W(16)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .out_valid(d4_out_valid), .out_ready(out_ready),
    .out_cycle(d4_out_cycle), .out_rd(d4_out_rd), .out_data(d4_out_data),
    .count(d4_count), .overflow(d4_overflow), .drop_count(d4_drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input trace_entry_t e);
    checkOutput({tag, ".valid"}, out_valid, 1);
    checkOutput({tag, ".cycle"}, out_cycle, e.cycle);
    checkOutput({tag, ".rd"},    out_rd,    e.rd);
    checkOutput({tag, ".data"},  out_data,  e.data);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic ready);
    ctrl_writeEnable = we;
    ctrl_writeReg    = rd;
    data_writeReg    = data;
    out_ready        = ready;
    tick();
  endtask

  task automatic doClear();
    clear = 1'b1;
    ctrl_writeEnable = 1'b0;
    out_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    trace_entry_t e;
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0; out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    checkOutput("reset.valid", out_valid, 0);
    checkOutput("reset.count", count, 0);
    checkOutput("reset.overflow", overflow, 0);
    checkOutput("reset.drop", drop_count, 0);
    checkOutput("reset.data", out_data, 0);

    // basic capture and drain
    enable = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 5, 7, 1);
    e = '{cycle: 12'd3, rd: 5'd5, data: 32'd7};
    checkHead("t1.first", e);
    checkOutput("t1.count1", count, 1);
    applyStimulus(1, 6, 32'hFFFF_FFFF, 1);
    e = '{cycle: 12'd4, rd: 5'd6, data: 32'hFFFF_FFFF};
    checkHead("t1.second", e);
    checkOutput("t1.count2", count, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t1.empty", count, 0);
    checkOutput("t1.valid", out_valid, 0);
    checkOutput("t1.zero", out_data, 0);

    // x0 writes are ignored
    applyStimulus(1, 0, 99, 1);
    checkOutput("t2.count", count, 0);
    checkOutput("t2.valid", out_valid, 0);

    // 17 writes into a 16-deep FIFO
    doClear();
    for (int i = 0; i < 17; i++) applyStimulus(1, 5'(i + 1), 32'(100 + i), 0);
    checkOutput("t3.count", count, 16);
    checkOutput("t3.overflow", overflow, 1);
    checkOutput("t3.drop", drop_count, EXP_DROP1);
    applyStimulus(0, 0, 0, 0);
    e = '{cycle: 12'd0, rd: 5'd1, data: 32'd100};
    checkHead("t3.hold", e);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e = '{cycle: 12'(i), rd: 5'(i + 1), data: 32'(100 + i)};
      checkHead($sformatf("t3.drain%0d", i), e);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("t3.empty", count, 0);
    checkOutput("t3.sticky", overflow, 1);
    doClear();
    checkOutput("t3.clr.overflow", overflow, 0);
    checkOutput("t3.clr.drop", drop_count, 0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) applyStimulus(1, 5'(i + 1), 32'(200 + i), 0);
    checkOutput("t4.full", count, 16);
    applyStimulus(1, 30, 999, 1);
    checkOutput("t4.count", count, 16);
    checkOutput("t4.overflow", overflow, 0);
    checkOutput("t4.drop", drop_count, 0);
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) e = '{cycle: 12'(i), rd: 5'(i + 1), data: 32'(200 + i)};
      else        e = '{cycle: 12'd16, rd: 5'd30, data: 32'd999};
      checkHead($sformatf("t4.drain%0d", i), e);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("t4.empty", count, 0);

    // enable low freezes the counter and blocks capture
    doClear();
    enable = 1'b0;
    repeat (3) applyStimulus(1, 7, 11, 1);
    checkOutput("en.count", count, 0);
    enable = 1'b1;
    applyStimulus(1, 7, 55, 0);
    e = '{cycle: 12'd0, rd: 5'd7, data: 32'd55};
    checkHead("en.stamp", e);

    // asynchronous reset mid-drain
    doClear();
    for (int i = 0; i < 5; i++) applyStimulus(1, 5'(i + 1), 32'(300 + i), 0);
    checkOutput("t6.count5", count, 5);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t6.count4", count, 4);
    ctrl_writeEnable = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("t6.async.valid", out_valid, 0);
    checkOutput("t6.async.count", count, 0);
    #1 reset = 1'b0;
    applyStimulus(1, 9, 77, 0);
    e = '{cycle: 12'd0, rd: 5'd9, data: 32'd77};
    checkHead("t6.restart", e);
    checkOutput("t6.count1", count, 1);

    // cycle-stamp wrap with CYC_W=4
    doClear();
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 3, 32'hABC, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    checkOutput("t5.d4.cycle", d4_out_cycle, 1);
    checkOutput("t5.d4.count", d4_count, 1);
    checkOutput("t5.d4.data", d4_out_data, 32'hABC);
    checkOutput("t5.main.cycle", out_cycle, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
